// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority-voted bit recovery, optional parity,
// sticky line-error flags and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 rxd,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  output logic                 full,
  output logic [FIFO_AW:0]     count,
  input  logic                 clr_err,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int unsigned RATE    = BAUD * OVERSAMPLE;
  localparam int unsigned DIV_RAW = (CLK_HZ + RATE / 2) / RATE;
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TICK_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W   = $clog2(DATA_BITS);
  localparam int unsigned PW      = FIFO_AW + 1;
  localparam int unsigned DEPTH   = 1 << FIFO_AW;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} state_t;

  // Two-flop synchroniser plus one history flop for edge detection
  logic rxd_m, rxd_s, rxd_p;
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_p <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_p <= rxd_s;
    end
  end

  state_t               state, state_n;
  logic [DIV_W-1:0]     div_cnt, div_n;
  logic [TICK_W-1:0]    tick_cnt, tick_n;
  logic [BIT_W-1:0]     bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 s0, s0_n, s1, s1_n;
  logic                 par_acc, par_acc_n, par_bad, par_bad_n;
  logic                 push_q, push_n, fe_set, pe_set;
  logic                 tick, samp_lo, samp_mid, samp_hi, vote, exp_par, fall;

  assign tick     = (div_cnt == DIV_W'(DIV - 1));
  assign samp_lo  = tick && (tick_cnt == TICK_W'(OVERSAMPLE / 2 - 1));
  assign samp_mid = tick && (tick_cnt == TICK_W'(OVERSAMPLE / 2));
  assign samp_hi  = tick && (tick_cnt == TICK_W'(OVERSAMPLE / 2 + 1));
  assign vote     = (s0 & s1) | (s0 & rxd_s) | (s1 & rxd_s);
  assign exp_par  = (PARITY == 2) ? ~par_acc : par_acc;
  assign fall     = rxd_p & ~rxd_s;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state      <= IDLE;
      div_cnt    <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      push_q     <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      div_cnt    <= div_n;
      tick_cnt   <= tick_n;
      bit_cnt    <= bit_n;
      shreg      <= shreg_n;
      s0         <= s0_n;
      s1         <= s1_n;
      par_acc    <= par_acc_n;
      par_bad    <= par_bad_n;
      push_q     <= push_n;
      frame_err  <= fe_set | (frame_err & ~clr_err);
      parity_err <= pe_set | (parity_err & ~clr_err);
    end
  end

  // Each state decides on its own third sample; the tick phase keeps running
  // across state changes so the next bit is sampled one bit period later.
  always_comb begin
    state_n   = state;
    div_n     = div_cnt;
    tick_n    = tick_cnt;
    bit_n     = bit_cnt;
    shreg_n   = shreg;
    s0_n      = s0;
    s1_n      = s1;
    par_acc_n = par_acc;
    par_bad_n = par_bad;
    push_n    = 1'b0;
    fe_set    = 1'b0;
    pe_set    = 1'b0;

    if (state != IDLE) begin
      if (tick) begin
        div_n  = '0;
        tick_n = (tick_cnt == TICK_W'(OVERSAMPLE - 1)) ? '0 : tick_cnt + TICK_W'(1);
      end else begin
        div_n  = div_cnt + DIV_W'(1);
      end
    end
    if (samp_lo)  s0_n = rxd_s;
    if (samp_mid) s1_n = rxd_s;

    case (state)
      IDLE: begin
        if (fall) begin
          state_n   = START;
          div_n     = '0;
          tick_n    = '0;
          bit_n     = '0;
          par_acc_n = 1'b0;
          par_bad_n = 1'b0;
        end
      end
      START: begin
        if (samp_hi) state_n = vote ? IDLE : DATA;
      end
      DATA: begin
        if (samp_hi) begin
          shreg_n   = {vote, shreg[DATA_BITS-1:1]};
          par_acc_n = par_acc ^ vote;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            state_n = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
          end
        end
      end
      PAR: begin
        if (samp_hi) begin
          par_bad_n = (vote != exp_par);
          state_n   = STOP;
        end
      end
      STOP: begin
        if (samp_hi) begin
          if (vote) begin
            state_n = IDLE;
            if (par_bad) pe_set = 1'b1;
            else         push_n = 1'b1;
          end else begin
            fe_set  = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxd_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FWFT FIFO: dout is a registered copy of the head entry
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]        wptr, rptr, wptr_n, rptr_n, count_n;
  logic                 pop, push_ok, ovr_set;

  assign pop     = rd & valid;
  assign push_ok = push_q & (~full | pop);
  assign ovr_set = push_q & full & ~pop;
  assign wptr_n  = wptr + PW'(push_ok);
  assign rptr_n  = rptr + PW'(pop);
  assign count_n = wptr_n - rptr_n;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[FIFO_AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      valid   <= 1'b0;
      full    <= 1'b0;
      dout    <= '0;
      overrun <= 1'b0;
    end else begin
      wptr    <= wptr_n;
      rptr    <= rptr_n;
      count   <= count_n;
      valid   <= (count_n != PW'(0));
      full    <= (count_n == PW'(DEPTH));
      overrun <= ovr_set | (overrun & ~clr_err);
      // New byte becomes head when the FIFO is, or is about to be, empty
      if (push_ok && ((count == PW'(0)) || (pop && (count == PW'(1))))) begin
        dout <= shreg;
      end else if (pop && (count > PW'(1))) begin
        dout <= mem[rptr_n[FIFO_AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and a 7-bit even-parity
// instance, both at a fast baud rate giving 64 clocks per bit.
module tb_uart_rx_fifo;

  localparam int unsigned CLK_HZ    = 100000000;
  localparam int unsigned BAUD      = 1562500;
  localparam int          BIT_CLKS  = 64;
  localparam int          IDLE_CLKS = 16;
  localparam int          PUSH_NEG  = 620;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       rxd0, rd0, clr0, valid0, full0, fe0, pe0, ov0;
  logic [7:0] dout0;
  logic [4:0] count0;
  logic       rxd1, rd1, clr1, valid1, full1, fe1, pe1, ov1;
  logic [6:0] dout1;
  logic [4:0] count1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(0), .FIFO_AW(4)) u_dut (
    .clk(clk), .reset_b(reset_b), .rxd(rxd0), .rd(rd0), .dout(dout0),
    .valid(valid0), .full(full0), .count(count0), .clr_err(clr0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0));

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(7),
                 .PARITY(1), .FIFO_AW(4)) u_par (
    .clk(clk), .reset_b(reset_b), .rxd(rxd1), .rd(rd1), .dout(dout1),
    .valid(valid1), .full(full1), .count(count1), .clr_err(clr1),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int line, input logic v);
    if (line == 0) rxd0 = v;
    else           rxd1 = v;
  endtask

  // par < 0: no parity bit; otherwise par[0] is sent as the parity bit
  task automatic send(input int line, input logic [7:0] data, input int nbits,
                      input int par, input logic stop_bit);
    @(negedge clk);
    drive(line, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      drive(line, data[i]);
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (par >= 0) begin
      drive(line, par[0]);
      repeat (BIT_CLKS) @(negedge clk);
    end
    drive(line, stop_bit);
    repeat (BIT_CLKS) @(negedge clk);
    drive(line, 1'b1);
    repeat (IDLE_CLKS) @(negedge clk);
  endtask

  task automatic pop0(input string tag, input logic [7:0] exp);
    check(tag, 32'(dout0), 32'(exp));
    rd0 = 1'b1;
    @(negedge clk);
    rd0 = 1'b0;
  endtask

  task automatic pulse_clr0();
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_b = 1'b0;
    rxd0 = 1'b1; rd0 = 1'b0; clr0 = 1'b0;
    rxd1 = 1'b1; rd1 = 1'b0; clr1 = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_dout",  32'(dout0),  32'h0);
    check("rst_valid", 32'(valid0), 32'h0);
    check("rst_full",  32'(full0),  32'h0);
    check("rst_count", 32'(count0), 32'h0);
    check("rst_errs",  32'({fe0, pe0, ov0, fe1, pe1, ov1}), 32'h0);
    reset_b = 1'b1;
    repeat (5) @(negedge clk);

    // Single 8N1 byte, then pop
    send(0, 8'h6C, 8, -1, 1'b1);
    check("t1_valid", 32'(valid0), 32'h1);
    check("t1_dout",  32'(dout0),  32'h6C);
    check("t1_count", 32'(count0), 32'h1);
    check("t1_errs",  32'({fe0, pe0, ov0}), 32'h0);
    pop0("t1_pop", 8'h6C);
    check("t1_valid_after", 32'(valid0), 32'h0);
    check("t1_count_after", 32'(count0), 32'h0);

    // Short low glitch on the idle line is rejected
    @(negedge clk);
    rxd0 = 1'b0;
    repeat (BIT_CLKS / 4) @(negedge clk);
    rxd0 = 1'b1;
    repeat (200) @(negedge clk);
    check("t2_count", 32'(count0), 32'h0);
    check("t2_valid", 32'(valid0), 32'h0);
    check("t2_fe",    32'(fe0),    32'h0);

    // Framing error, then a good byte
    send(0, 8'h41, 8, -1, 1'b0);
    check("t3_fe_set", 32'(fe0), 32'h1);
    send(0, 8'h42, 8, -1, 1'b1);
    check("t3_count", 32'(count0), 32'h1);
    check("t3_dout",  32'(dout0),  32'h42);
    check("t3_fe",    32'(fe0),    32'h1);
    pulse_clr0();
    check("t3_fe_clr", 32'(fe0), 32'h0);
    pop0("t3_pop", 8'h42);

    // Fill past capacity: 17 bytes, last one dropped
    for (int b = 0; b <= 16; b++) send(0, 8'(b), 8, -1, 1'b1);
    check("t4_count",   32'(count0), 32'd16);
    check("t4_full",    32'(full0),  32'h1);
    check("t4_overrun", 32'(ov0),    32'h1);
    check("t4_dout",    32'(dout0),  32'h00);
    for (int b = 0; b < 16; b++) pop0("t4_pop", 8'(b));
    check("t4_empty", 32'({valid0, full0, count0}), 32'h0);

    // Parity instance: good, bad (with clr_err on the same clock), good
    send(1, 8'h35, 7, 0, 1'b1);
    check("t5_count", 32'(count1), 32'h1);
    check("t5_dout",  32'(dout1),  32'h35);
    check("t5_pe0",   32'(pe1),    32'h0);
    fork
      send(1, 8'h35, 7, 1, 1'b1);
      begin
        clr1 = 1'b1;
        repeat (PUSH_NEG) @(negedge clk);
        clr1 = 1'b0;
      end
    join
    check("t5_pe_set",  32'(pe1),    32'h1);
    check("t5_count_2", 32'(count1), 32'h1);
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    @(negedge clk);
    check("t5_pe_clr", 32'(pe1), 32'h0);
    send(1, 8'h07, 7, 1, 1'b1);
    check("t5_count_3", 32'(count1), 32'h2);
    check("t5_head",    32'(dout1),  32'h35);
    check("t5_fe",      32'({fe1, pe1, ov1}), 32'h0);

    // Full FIFO with a pop on the push clock
    pulse_clr0();
    check("t6_ov_clr", 32'(ov0), 32'h0);
    for (int b = 0; b < 16; b++) send(0, 8'(8'h20 + b), 8, -1, 1'b1);
    check("t6_full", 32'(full0), 32'h1);
    fork
      send(0, 8'h30, 8, -1, 1'b1);
      begin
        repeat (PUSH_NEG) @(negedge clk);
        rd0 = 1'b1;
        @(negedge clk);
        rd0 = 1'b0;
      end
    join
    check("t6_count",   32'(count0), 32'd16);
    check("t6_overrun", 32'(ov0),    32'h0);
    check("t6_full2",   32'(full0),  32'h1);
    for (int b = 1; b <= 16; b++) pop0("t6_pop", 8'(8'h20 + b));

    // Pop while empty is ignored
    pop0("t6_rd_empty_dout", 8'h30);
    check("t6_rd_empty", 32'({valid0, count0}), 32'h0);
    send(0, 8'h77, 8, -1, 1'b1);
    check("t6_after_empty", 32'({valid0, count0}), 32'h21);

    // Reset mid-DATA empties the FIFO; next frame is clean
    fork
      send(0, 8'h5A, 8, -1, 1'b1);
      begin
        repeat (300) @(negedge clk);
        reset_b = 1'b0;
      end
    join
    check("t7_count_rst", 32'(count0), 32'h0);
    check("t7_valid_rst", 32'(valid0), 32'h0);
    reset_b = 1'b1;
    repeat (10) @(negedge clk);
    send(0, 8'hA5, 8, -1, 1'b1);
    check("t7_count", 32'(count0), 32'h1);
    check("t7_dout",  32'(dout0),  32'hA5);
    check("t7_errs",  32'({fe0, pe0, ov0}), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
